// File: rtl/load_store_unit_if.sv
// Bundles the pipeline request, data-memory and response signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the pipeline and memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        rsp_is_load;

  modport slave (
    input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_read, mem_write, mem_addr, mem_write_data, mem_byte_enable,
    input  mem_read_data,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_is_load,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_read, mem_write, mem_addr, mem_write_data, mem_byte_enable,
    output mem_read_data,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_is_load,
    output rsp_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: one-cycle memory access, then a held response.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of force-aligning them.
//
// state  | meaning
// IDLE   | no request held, ready to accept
// ACCESS | drive the data memory for the held request
// RESP   | present the response until rsp_ready
module load_store_unit (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        req_load_q, req_load_d;
  logic [2:0]  req_funct3_q, req_funct3_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_is_load_q, rsp_is_load_d;

  logic        accept;
  logic        illegal;
  logic        misalign;
  logic        ok;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign bus.req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  // Stores have no unsigned variants, so funct3[2] on a store is illegal.
  assign illegal = (req_funct3_q == 3'b011) | (req_funct3_q == 3'b110) |
                   (req_funct3_q == 3'b111) | (~req_load_q & req_funct3_q[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3_q[1:0] == 2'b01) & req_addr_q[0]) |
                    ((req_funct3_q == 3'b010) & (req_addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign ok = ~illegal & ~misalign;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = 32'h0;
    case (req_funct3_q[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << req_addr_q[1:0];
        wdata_rep = {4{req_wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << {req_addr_q[1], 1'b0};
        wdata_rep = {2{req_wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        wdata_rep = req_wdata_q;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'h0;
    case (req_addr_q[1:0])
      2'b00:   byte_sel = bus.mem_read_data[7:0];
      2'b01:   byte_sel = bus.mem_read_data[15:8];
      2'b10:   byte_sel = bus.mem_read_data[23:16];
      default: byte_sel = bus.mem_read_data[31:24];
    endcase
    half_sel = req_addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    load_ext = 32'h0;
    case (req_funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      3'b010:  load_ext = bus.mem_read_data;
      default: load_ext = 32'h0;
    endcase
  end

  // Memory outputs are live only in ACCESS; lanes and data are gated when the access is suppressed.
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_addr        = 32'h0;
    bus.mem_write_data  = 32'h0;
    bus.mem_byte_enable = 4'b0000;
    if (state_q == ST_ACCESS) begin
      bus.mem_read        = req_load_q & ok;
      bus.mem_write       = ~req_load_q & ok;
      bus.mem_addr        = {req_addr_q[31:2], 2'b00};
      bus.mem_byte_enable = ok ? byte_en : 4'b0000;
      bus.mem_write_data  = (ok & ~req_load_q) ? wdata_rep : 32'h0;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_load_d    = req_load_q;
    req_funct3_d  = req_funct3_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_rd_d      = req_rd_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_err_d     = rsp_err_q;
    rsp_is_load_d = rsp_is_load_q;

    if (accept) begin
      req_load_d   = bus.req_load;
      req_funct3_d = bus.req_funct3;
      req_addr_d   = bus.req_addr;
      req_wdata_d  = bus.req_wdata;
      req_rd_d     = bus.req_rd;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d       = ST_RESP;
        rsp_rd_d      = req_rd_q;
        rsp_is_load_d = req_load_q;
        rsp_err_d     = ~ok;
        rsp_rdata_d   = (req_load_q & ok) ? load_ext : 32'h0;
      end
      ST_RESP: begin
        if (accept)             state_d = ST_ACCESS;
        else if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_load_q    <= 1'b0;
      req_funct3_q  <= 3'b000;
      req_addr_q    <= 32'h0;
      req_wdata_q   <= 32'h0;
      req_rd_q      <= 5'd0;
      rsp_rdata_q   <= 32'h0;
      rsp_rd_q      <= 5'd0;
      rsp_err_q     <= 1'b0;
      rsp_is_load_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_load_q    <= req_load_d;
      req_funct3_q  <= req_funct3_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_rd_q      <= req_rd_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_err_q     <= rsp_err_d;
      rsp_is_load_q <= rsp_is_load_d;
    end
  end

  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_is_load = rsp_is_load_q;

endmodule
